// File: rtl/or_frame_accumulator_if.sv
// Stream interface for or_frame_accumulator: a word input channel and a
// frame-result output channel, both valid/ready.
// Optional macro OR_FRAME_FIRST_HIT_EN adds the first-hit result signals.
interface or_frame_accumulator_if #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 8
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_any;
   logic [CNT_W-1:0] out_count;
`ifdef OR_FRAME_FIRST_HIT_EN
   logic [CNT_W-1:0] out_first_hit;
   logic             out_hit;
`endif

   // Accumulator side: consumes words, produces frame results.
   modport slave (
      input  mode, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_any, out_count
`ifdef OR_FRAME_FIRST_HIT_EN
      , output out_first_hit, out_hit
`endif
   );

   // Environment side: produces words, consumes frame results.
   modport master (
      output mode, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_any, out_count
`ifdef OR_FRAME_FIRST_HIT_EN
      , input out_first_hit, out_hit
`endif
   );
endinterface

// File: rtl/or_frame_accumulator.sv
// or_frame_accumulator: folds a stream of WIDTH-bit words into one word by
// bitwise OR over a frame of up to FRAME_LEN beats, then presents the OR (or
// NOR, chosen by mode on the first beat) until the consumer takes it.
// Optional macro OR_FRAME_FIRST_HIT_EN adds out_hit / out_first_hit, the
// index of the first nonzero beat in the frame.
module or_frame_accumulator #(
   parameter int WIDTH     = 16,
   parameter int FRAME_LEN = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   or_frame_accumulator_if.slave  bus
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_any_q, out_any_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic [WIDTH-1:0] acc_nxt;
   logic             mode_nxt;
`ifdef OR_FRAME_FIRST_HIT_EN
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] first_hit_q, first_hit_d;
`endif

   // State and result registers; reset discards any partial or held frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         out_data_q  <= '0;
         out_any_q   <= 1'b0;
         out_count_q <= '0;
`ifdef OR_FRAME_FIRST_HIT_EN
         hit_q       <= 1'b0;
         first_hit_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_any_q   <= out_any_d;
         out_count_q <= out_count_d;
`ifdef OR_FRAME_FIRST_HIT_EN
         hit_q       <= hit_d;
         first_hit_q <= first_hit_d;
`endif
      end
   end

   // Next-state: accumulate beats in ACCUM, latch the result on the closing
   // beat, and clear everything when the consumer takes the result.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_any_d   = out_any_q;
      out_count_d = out_count_q;
      acc_nxt     = acc_q;
      mode_nxt    = mode_q;
`ifdef OR_FRAME_FIRST_HIT_EN
      hit_d       = hit_q;
      first_hit_d = first_hit_q;
`endif
      case (state_q)
         ACCUM: begin
            if (bus.in_valid) begin
               // First beat seeds the accumulator and fixes the frame mode.
               if (cnt_q == '0) begin
                  acc_nxt  = bus.in_data;
                  mode_nxt = bus.mode;
               end else begin
                  acc_nxt  = acc_q | bus.in_data;
                  mode_nxt = mode_q;
               end
               acc_d  = acc_nxt;
               mode_d = mode_nxt;
               cnt_d  = cnt_q + CNT_W'(1);
`ifdef OR_FRAME_FIRST_HIT_EN
               if (!hit_q && (|bus.in_data)) begin
                  hit_d       = 1'b1;
                  first_hit_d = cnt_q;
               end
`endif
               // A frame closes on in_last or on its FRAME_LEN-th beat, so the
               // count can never exceed FRAME_LEN.
               if (bus.in_last || (cnt_q == LAST_IDX)) begin
                  state_d     = HOLD;
                  out_data_d  = mode_nxt ? ~acc_nxt : acc_nxt;
                  out_any_d   = |acc_nxt;
                  out_count_d = cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d     = ACCUM;
               acc_d       = '0;
               cnt_d       = '0;
               out_data_d  = '0;
               out_any_d   = 1'b0;
               out_count_d = '0;
`ifdef OR_FRAME_FIRST_HIT_EN
               hit_d       = 1'b0;
               first_hit_d = '0;
`endif
            end
         end
      endcase
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_any   = out_any_q;
   assign bus.out_count = out_count_q;
`ifdef OR_FRAME_FIRST_HIT_EN
   assign bus.out_hit       = hit_q;
   assign bus.out_first_hit = first_hit_q;
`endif

endmodule
